control_unit: RTL

- Hardwired Moore controller that sequences the CPU datapath through fetch, decode and execute.
- Replaces the per-instruction testbench drivers that currently hand-drive PCout, IRin, Gra, Rout and similar signals.
- Sits beside the datapath: reads the IR and the CON flag, and drives every bus, register-enable, memory and I/O strobe.
- Instruction cost is 3 fetch cycles plus 1–5 execute cycles.

---
 rtl/cpu_ctrl_pkg.sv | 109 ++++++++++
 rtl/ctrl_decode.sv | 53 +++++
 rtl/control_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the hardwired CPU controller:
//   - opcode field / step counter widths
//   - opcode values (IR[31:27])
//   - controller state encoding
//   - instruction classes produced by ctrl_decode
//   - strobe bundle used internally by control_unit
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    localparam int OPC_W  = 5;
    localparam int STEP_W = 3;

    // Execute steps are numbered T3..T7 so the counter value equals the step.
    localparam logic [STEP_W-1:0] FIRST_EX_STEP = 3'd3;

    localparam logic [OPC_W-1:0] OP_LD   = 5'd0;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'd1;
    localparam logic [OPC_W-1:0] OP_ST   = 5'd2;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'd3;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'd4;
    localparam logic [OPC_W-1:0] OP_AND  = 5'd5;
    localparam logic [OPC_W-1:0] OP_OR   = 5'd6;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'd7;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'd8;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'd9;
    localparam logic [OPC_W-1:0] OP_SHRA = 5'd10;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'd11;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'd12;
    localparam logic [OPC_W-1:0] OP_ANDI = 5'd13;
    localparam logic [OPC_W-1:0] OP_ORI  = 5'd14;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'd15;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'd16;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'd17;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'd18;
    localparam logic [OPC_W-1:0] OP_BR   = 5'd19;
    localparam logic [OPC_W-1:0] OP_JR   = 5'd20;
    localparam logic [OPC_W-1:0] OP_JAL  = 5'd21;
    localparam logic [OPC_W-1:0] OP_IN   = 5'd22;
    localparam logic [OPC_W-1:0] OP_OUT  = 5'd23;
    localparam logic [OPC_W-1:0] OP_MFHI = 5'd24;
    localparam logic [OPC_W-1:0] OP_MFLO = 5'd25;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'd26;
    localparam logic [OPC_W-1:0] OP_HALT = 5'd27;

    // Address arithmetic (ld/ldi/st/br) always uses the ALU's add function.
    localparam logic [OPC_W-1:0] ALU_ADD = OP_ADD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_EX,
        ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        CL_LOAD,
        CL_LOADI,
        CL_STORE,
        CL_ALU3,
        CL_ALUI,
        CL_MULDIV,
        CL_UNARY,
        CL_BR,
        CL_JR,
        CL_JAL,
        CL_IN,
        CL_OUT,
        CL_MFHI,
        CL_MFLO,
        CL_NOP,
        CL_HALT
    } iclass_t;

    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic mem_read;
        logic mdr_in;
        logic mdr_out;
        logic ram_enable;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic zlow_out;
        logic zhigh_out;
        logic hi_in;
        logic lo_in;
        logic hi_out;
        logic lo_out;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic ba_out;
        logic c_out;
        logic con_in;
        logic inport_out;
        logic outport_in;
        logic r15_in;
    } strobes_t;

endpackage

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Purely combinational opcode classifier.
//   opcode_i    : IR[31:27]
//   iclass_o    : instruction class driving the execute-step decode
//   last_step_o : index (3..7) of the final execute step for this class
// Opcodes 28..31 are treated as nop.
// ---------------------------------------------------------------------------
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0]  opcode_i,
    output iclass_t           iclass_o,
    output logic [STEP_W-1:0] last_step_o
);

    always_comb begin
        unique case (opcode_i)
            OP_LD:   iclass_o = CL_LOAD;
            OP_LDI:  iclass_o = CL_LOADI;
            OP_ST:   iclass_o = CL_STORE;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:
                     iclass_o = CL_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI:
                     iclass_o = CL_ALUI;
            OP_DIV, OP_MUL:
                     iclass_o = CL_MULDIV;
            OP_NEG, OP_NOT:
                     iclass_o = CL_UNARY;
            OP_BR:   iclass_o = CL_BR;
            OP_JR:   iclass_o = CL_JR;
            OP_JAL:  iclass_o = CL_JAL;
            OP_IN:   iclass_o = CL_IN;
            OP_OUT:  iclass_o = CL_OUT;
            OP_MFHI: iclass_o = CL_MFHI;
            OP_MFLO: iclass_o = CL_MFLO;
            OP_HALT: iclass_o = CL_HALT;
            default: iclass_o = CL_NOP;
        endcase
    end

    always_comb begin
        unique case (iclass_o)
            CL_LOAD, CL_STORE:           last_step_o = 3'd7;
            CL_MULDIV, CL_BR:            last_step_o = 3'd6;
            CL_LOADI, CL_ALU3, CL_ALUI:  last_step_o = 3'd5;
            CL_UNARY, CL_JAL:            last_step_o = 3'd4;
            default:                     last_step_o = 3'd3;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Hardwired Moore controller sequencing the datapath through fetch (T0..T2)
// and execute (T3..T7).
//   clock  : system clock, rising edge
//   clear  : asynchronous active-high reset -> IDLE, all outputs 0
//   run    : permits leaving IDLE / chaining into the next fetch
//   ir     : instruction register contents (opcode = ir[31:27])
//   con    : branch condition from the CON flip-flop
//   halted : high while parked in HALT
//   strobes: one-cycle bus / register / memory / I/O controls
//   alu_op : ALU function select (opcode encoding), 0 unless Zin is high
// ---------------------------------------------------------------------------
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        con,
    output logic        halted,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        memRead,
    output logic        MDRin,
    output logic        MDRout,
    output logic        ramEnable,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic        HIout,
    output logic        LOout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        CONin,
    output logic        InPort_Out,
    output logic        OutPort_In,
    output logic        R15in,
    output logic [4:0]  alu_op
);

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    iclass_t           iclass;
    logic [STEP_W-1:0] last_step;
    logic [OPC_W-1:0]  opcode;
    strobes_t          st;
    logic [OPC_W-1:0]  alu_op_c;
    logic              ir_operands_unused;

    assign opcode = ir[31:27];
    // Operand fields are consumed by the datapath, not by the controller.
    assign ir_operands_unused = ^ir[26:0];

    ctrl_decode u_decode (
        .opcode_i    (opcode),
        .iclass_o    (iclass),
        .last_step_o (last_step)
    );

    // ---------------- next-state logic ----------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned (which would infer a latch).
        state_d = state_q;
        step_d  = step_q;
        unique case (state_q)
            ST_IDLE: if (run) state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2: begin
                state_d = ST_EX;
                step_d  = FIRST_EX_STEP;
            end
            ST_EX: begin
                if (step_q == last_step) begin
                    step_d = FIRST_EX_STEP;
                    if (iclass == CL_HALT) state_d = ST_HALT;
                    else                   state_d = run ? ST_T0 : ST_IDLE;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            step_q  <= FIRST_EX_STEP;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // ---------------- strobe decode ----------------
    always_comb begin
        st       = '0;
        alu_op_c = '0;
        unique case (state_q)
            ST_T0: begin
                st.pc_out = 1'b1; st.mar_in = 1'b1; st.inc_pc = 1'b1;
            end
            ST_T1: begin
                st.mem_read = 1'b1; st.mdr_in = 1'b1;
            end
            ST_T2: begin
                st.mdr_out = 1'b1; st.ir_in = 1'b1;
            end
            ST_EX: begin
                unique case (iclass)
                    // ld / ldi / st share the effective-address computation.
                    CL_LOAD, CL_LOADI, CL_STORE: begin
                        unique case (step_q)
                            3'd3: begin st.grb = 1'b1; st.ba_out = 1'b1; st.y_in = 1'b1; end
                            3'd4: begin st.c_out = 1'b1; st.z_in = 1'b1; alu_op_c = ALU_ADD; end
                            3'd5: begin
                                st.zlow_out = 1'b1;
                                if (iclass == CL_LOADI) begin
                                    st.gra = 1'b1; st.r_in = 1'b1;
                                end else begin
                                    st.mar_in = 1'b1;
                                end
                            end
                            3'd6: begin
                                if (iclass == CL_LOAD) begin
                                    st.mem_read = 1'b1; st.mdr_in = 1'b1;
                                end else begin
                                    st.gra = 1'b1; st.r_out = 1'b1; st.mdr_in = 1'b1;
                                end
                            end
                            default: begin
                                if (iclass == CL_LOAD) begin
                                    st.mdr_out = 1'b1; st.gra = 1'b1; st.r_in = 1'b1;
                                end else begin
                                    st.ram_enable = 1'b1;
                                end
                            end
                        endcase
                    end
                    CL_ALU3, CL_ALUI: begin
                        unique case (step_q)
                            3'd3: begin st.grb = 1'b1; st.r_out = 1'b1; st.y_in = 1'b1; end
                            3'd4: begin
                                st.z_in  = 1'b1;
                                alu_op_c = opcode;
                                if (iclass == CL_ALU3) begin
                                    st.grc = 1'b1; st.r_out = 1'b1;
                                end else begin
                                    st.c_out = 1'b1;
                                end
                            end
                            default: begin st.zlow_out = 1'b1; st.gra = 1'b1; st.r_in = 1'b1; end
                        endcase
                    end
                    CL_MULDIV: begin
                        unique case (step_q)
                            3'd3: begin st.gra = 1'b1; st.r_out = 1'b1; st.y_in = 1'b1; end
                            3'd4: begin st.grb = 1'b1; st.r_out = 1'b1; st.z_in = 1'b1; alu_op_c = opcode; end
                            3'd5: begin st.zlow_out = 1'b1; st.lo_in = 1'b1; end
                            default: begin st.zhigh_out = 1'b1; st.hi_in = 1'b1; end
                        endcase
                    end
                    CL_UNARY: begin
                        if (step_q == 3'd3) begin
                            st.grb = 1'b1; st.r_out = 1'b1; st.z_in = 1'b1; alu_op_c = opcode;
                        end else begin
                            st.zlow_out = 1'b1; st.gra = 1'b1; st.r_in = 1'b1;
                        end
                    end
                    CL_BR: begin
                        unique case (step_q)
                            3'd3: begin st.gra = 1'b1; st.r_out = 1'b1; st.con_in = 1'b1; end
                            3'd4: begin st.pc_out = 1'b1; st.y_in = 1'b1; end
                            3'd5: begin st.c_out = 1'b1; st.z_in = 1'b1; alu_op_c = ALU_ADD; end
                            // Branch not taken leaves the final step idle.
                            default: begin st.zlow_out = con; st.pc_in = con; end
                        endcase
                    end
                    CL_JR: begin
                        st.gra = 1'b1; st.r_out = 1'b1; st.pc_in = 1'b1;
                    end
                    CL_JAL: begin
                        if (step_q == 3'd3) begin
                            st.pc_out = 1'b1; st.r15_in = 1'b1;
                        end else begin
                            st.gra = 1'b1; st.r_out = 1'b1; st.pc_in = 1'b1;
                        end
                    end
                    CL_IN:   begin st.inport_out = 1'b1; st.gra = 1'b1; st.r_in = 1'b1; end
                    CL_OUT:  begin st.gra = 1'b1; st.r_out = 1'b1; st.outport_in = 1'b1; end
                    CL_MFHI: begin st.hi_out = 1'b1; st.gra = 1'b1; st.r_in = 1'b1; end
                    CL_MFLO: begin st.lo_out = 1'b1; st.gra = 1'b1; st.r_in = 1'b1; end
                    default: ; // nop and halt drive nothing during T3
                endcase
            end
            default: ; // IDLE and HALT drive no strobes
        endcase
    end

    assign halted     = (state_q == ST_HALT);
    assign alu_op     = alu_op_c;
    assign PCout      = st.pc_out;
    assign PCin       = st.pc_in;
    assign IncPC      = st.inc_pc;
    assign MARin      = st.mar_in;
    assign memRead    = st.mem_read;
    assign MDRin      = st.mdr_in;
    assign MDRout     = st.mdr_out;
    assign ramEnable  = st.ram_enable;
    assign IRin       = st.ir_in;
    assign Yin        = st.y_in;
    assign Zin        = st.z_in;
    assign Zlowout    = st.zlow_out;
    assign Zhighout   = st.zhigh_out;
    assign HIin       = st.hi_in;
    assign LOin       = st.lo_in;
    assign HIout      = st.hi_out;
    assign LOout      = st.lo_out;
    assign Gra        = st.gra;
    assign Grb        = st.grb;
    assign Grc        = st.grc;
    assign Rin        = st.r_in;
    assign Rout       = st.r_out;
    assign BAout      = st.ba_out;
    assign Cout       = st.c_out;
    assign CONin      = st.con_in;
    assign InPort_Out = st.inport_out;
    assign OutPort_In = st.outport_in;
    assign R15in      = st.r15_in;

endmodule
